// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for async_fifo: pops the FIFO and re-presents words as a valid/ready stream.
// Optional end-of-packet marker built only when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream #(
    parameter int unsigned Width  = 8,
    parameter int unsigned PktLen = 4
) (
    input  logic             clk_rd,
    input  logic             rst_n,
    output logic             o_rd_en,
    input  logic [Width-1:0] i_rd_data,
    input  logic             i_empty,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data,
    output logic             o_last,
    output logic             o_busy
);

    logic [Width-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic             pop;
    logic [2:0]       occ_next;

    // occ_next is the buffer count after this edge; a new pop is only issued
    // when that slot plus the word it launches still fits in two entries.
    always_comb begin
        pop      = o_valid & i_ready;
        occ_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        o_rd_en  = rst_n & ~i_empty & (occ_next < 3'd2);
    end

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            inflight <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= o_rd_en;
            count    <= occ_next[1:0];
            if (inflight) begin
                buf_mem[wr_ptr] <= i_rd_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign o_valid = (count != 2'd0);
    assign o_data  = buf_mem[rd_ptr];
    assign o_busy  = (count != 2'd0) | inflight;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam logic [15:0] LastBeat = 16'(PktLen - 1);

    logic [15:0] beat;

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (pop) begin
            beat <= o_last ? '0 : beat + 16'd1;
        end
    end

    assign o_last = o_valid & (beat == LastBeat);
`else
    // PktLen only matters with the marker enabled; reference it so it is not flagged unused.
    assign o_last = 1'b0 & (PktLen == 0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT and a
// scoreboard checks ordering, occupancy, stream stability and the packet marker.
module tb_fifo_rd_stream;

    localparam int unsigned W   = 8;
    localparam int unsigned PKT = 4;
`ifdef FIFO_RD_STREAM_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic         clk_rd    = 1'b0;
    logic         rst_n     = 1'b0;
    logic         o_rd_en;
    logic [W-1:0] i_rd_data = '0;
    logic         i_empty   = 1'b1;
    logic         o_valid;
    logic         i_ready   = 1'b0;
    logic [W-1:0] o_data;
    logic         o_last;
    logic         o_busy;

    fifo_rd_stream #(.Width(W), .PktLen(PKT)) dut (
        .clk_rd   (clk_rd),
        .rst_n    (rst_n),
        .o_rd_en  (o_rd_en),
        .i_rd_data(i_rd_data),
        .i_empty  (i_empty),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_busy   (o_busy)
    );

    always #5 clk_rd = ~clk_rd;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];
    logic [W-1:0] got_q  [$];
    logic         last_q [$];

    logic         force_empty = 1'b0;
    logic         rd_en_s     = 1'b0;
    int           issued      = 0;
    int           delivered   = 0;
    logic         prev_valid  = 1'b0;
    logic         prev_ready  = 1'b0;
    logic [W-1:0] prev_data   = '0;

    int           occ;
    logic         hs;
    logic         exp_last;
    logic [W-1:0] exp_word;

    // FIFO model: read data appears the cycle after a pop; empty flag is registered.
    always @(posedge clk_rd) begin
        if (rst_n && rd_en_s && fifo_q.size() != 0) begin
            i_rd_data <= fifo_q.pop_front();
        end
        i_empty <= force_empty || (fifo_q.size() == 0);
    end

    // Monitor: occupancy = words popped from the FIFO but not yet accepted downstream.
    always @(negedge clk_rd) begin
        if (!rst_n) begin
            rd_en_s    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            occ = issued - delivered;
            total++;
            if (occ < 0 || occ > 2)
                $display("FAIL occupancy: got %0d required 0..2", occ);
            if (occ < 0 || occ > 2) bad++;
            total++;
            if (o_busy !== (occ != 0)) begin
                $display("FAIL busy: got %b required %b", o_busy, (occ != 0));
                bad++;
            end
            total++;
            if (o_rd_en === 1'b1 && i_empty === 1'b1) begin
                $display("FAIL rd_en_while_empty: got o_rd_en=%b required 0", o_rd_en);
                bad++;
            end
            if (prev_valid && !prev_ready) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== prev_data) begin
                    $display("FAIL stall_hold: got valid=%b data=%0h required valid=1 data=%0h",
                             o_valid, o_data, prev_data);
                    bad++;
                end
            end
            exp_last = LAST_EN && (o_valid === 1'b1) && ((delivered % PKT) == PKT - 1);
            total++;
            if (o_last !== exp_last) begin
                $display("FAIL last_flag: got %b required %b", o_last, exp_last);
                bad++;
            end
            hs = (o_valid === 1'b1) && (i_ready === 1'b1);
            if (hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_word: got %0h required none", o_data);
                    bad++;
                end else begin
                    exp_word = exp_q.pop_front();
                    if (o_data !== exp_word) begin
                        $display("FAIL stream_data: got %0h required %0h", o_data, exp_word);
                        bad++;
                    end
                end
                got_q.push_back(o_data);
                last_q.push_back(o_last);
            end
            issued    += (o_rd_en === 1'b1) ? 1 : 0;
            delivered += hs ? 1 : 0;
            rd_en_s    = (o_rd_en === 1'b1);
            prev_valid = (o_valid === 1'b1);
            prev_ready = i_ready;
            prev_data  = o_data;
        end
    end

    task automatic tick();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic look();
        @(negedge clk_rd);
        #1;
    endtask

    // Assert reset (FIFO model is reset too) and preload n words starting at base.
    task automatic do_reset(input int n, input logic [W-1:0] base);
        tick();
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        got_q.delete();
        last_q.delete();
        issued      = 0;
        delivered   = 0;
        force_empty = 1'b0;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + W'(i));
            exp_q.push_back(base + W'(i));
        end
        repeat (3) tick();
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        tick();
        i_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            look();
            if (exp_q.size() == 0 && o_busy === 1'b0) begin
                done = 1;
                break;
            end
        end
        total++;
        if (!done) begin
            $display("FAIL drain_timeout: got %0d words pending required 0", exp_q.size());
            bad++;
        end
    endtask

    task automatic test_reset();
        i_ready = 1'b1;
        do_reset(4, 8'h10);
        look();
        total++;
        if (o_rd_en !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0 ||
            o_data !== '0 || o_last !== 1'b0) begin
            $display("FAIL reset_values: got rd_en=%b valid=%b busy=%b data=%0h last=%b required all 0",
                     o_rd_en, o_valid, o_busy, o_data, o_last);
            bad++;
        end
        tick();
        rst_n = 1'b1;
        look();
        total++;
        if (o_rd_en !== 1'b1) begin
            $display("FAIL first_rd_en: got %b required 1", o_rd_en);
            bad++;
        end
        drain(30);
    endtask

    task automatic test_streaming();
        logic v [12];
        logic first_rd;
        i_ready = 1'b1;
        do_reset(8, 8'h01);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            look();
            v[c] = o_valid;
            if (c == 0) first_rd = o_rd_en;
            if (c == 10) begin
                total++;
                if (o_busy !== 1'b0) begin
                    $display("FAIL stream_idle_busy: got %b required 0", o_busy);
                    bad++;
                end
            end
        end
        total++;
        if (first_rd !== 1'b1) begin
            $display("FAIL stream_first_rd: got %b required 1", first_rd);
            bad++;
        end
        for (int c = 0; c < 12; c++) begin
            total++;
            if (v[c] !== (c >= 2 && c <= 9)) begin
                $display("FAIL stream_valid_c%0d: got %b required %b", c, v[c], (c >= 2 && c <= 9));
                bad++;
            end
        end
        total++;
        if (got_q.size() != 8) begin
            $display("FAIL stream_count: got %0d required 8", got_q.size());
            bad++;
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== W'(k + 1)) begin
                $display("FAIL stream_word_%0d: got %0h required %0h",
                         k, (k < got_q.size()) ? got_q[k] : '0, W'(k + 1));
                bad++;
            end
        end
    endtask

    task automatic test_backpressure();
        int n_rd = 0;
        i_ready = 1'b0;
        do_reset(5, 8'h01);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            look();
            n_rd += (o_rd_en === 1'b1) ? 1 : 0;
            if (c >= 2) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== 8'h01) begin
                    $display("FAIL bp_head_c%0d: got valid=%b data=%0h required valid=1 data=01",
                             c, o_valid, o_data);
                    bad++;
                end
            end
        end
        total++;
        if (n_rd != 2) begin
            $display("FAIL bp_pop_count: got %0d required 2", n_rd);
            bad++;
        end
        drain(40);
        total++;
        if (got_q.size() != 5) begin
            $display("FAIL bp_count: got %0d required 5", got_q.size());
            bad++;
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= got_q.size() || got_q[k] !== W'(k + 1)) begin
                $display("FAIL bp_word_%0d: got %0h required %0h",
                         k, (k < got_q.size()) ? got_q[k] : '0, W'(k + 1));
                bad++;
            end
        end
    endtask

    task automatic test_empty_race();
        i_ready = 1'b1;
        do_reset(3, 8'h40);
        tick();
        rst_n       = 1'b1;
        force_empty = 1'b1;
        look();
        total++;
        if (o_rd_en !== 1'b1) begin
            $display("FAIL race_first_rd: got %b required 1", o_rd_en);
            bad++;
        end
        look();
        total++;
        if (o_rd_en !== 1'b0) begin
            $display("FAIL race_no_rd: got %b required 0", o_rd_en);
            bad++;
        end
        repeat (5) look();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h40 || o_busy !== 1'b0) begin
            $display("FAIL race_inflight: got n=%0d busy=%b required n=1 word=40 busy=0",
                     got_q.size(), o_busy);
            bad++;
        end
        tick();
        force_empty = 1'b0;
        drain(30);
        total++;
        if (got_q.size() != 3 || got_q[1] !== 8'h41 || got_q[2] !== 8'h42) begin
            $display("FAIL race_rest: got n=%0d required 3 words 40..42", got_q.size());
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        do_reset(6, 8'h60);
        tick();
        rst_n = 1'b1;
        repeat (4) look();
        total++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
            $display("FAIL mid_pre: got valid=%b busy=%b required 1 1", o_valid, o_busy);
            bad++;
        end
        tick();
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        got_q.delete();
        last_q.delete();
        issued    = 0;
        delivered = 0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
            $display("FAIL mid_async_clear: got valid=%b busy=%b rd_en=%b required 0 0 0",
                     o_valid, o_busy, o_rd_en);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(8'h70 + W'(i));
            exp_q.push_back(8'h70 + W'(i));
        end
        tick();
        rst_n = 1'b1;
        drain(40);
        total++;
        if (got_q.size() != 4 || got_q[0] !== 8'h70 || got_q[3] !== 8'h73) begin
            $display("FAIL mid_resume: got n=%0d required 4 words 70..73", got_q.size());
            bad++;
        end
    endtask

    task automatic test_random();
        int n_push = 0;
        logic [W-1:0] w;
        i_ready = 1'b0;
        do_reset(0, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            i_ready     = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) != 0) begin
                w = W'($urandom);
                fifo_q.push_back(w);
                exp_q.push_back(w);
                n_push++;
            end
        end
        tick();
        force_empty = 1'b0;
        drain(200);
        total++;
        if (got_q.size() != n_push) begin
            $display("FAIL random_count: got %0d required %0d", got_q.size(), n_push);
            bad++;
        end
    endtask

    task automatic test_last();
        i_ready = 1'b0;
        do_reset(8, 8'h80);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 100 && got_q.size() < 8; c++) begin
            tick();
            i_ready = ($urandom_range(0, 1) != 0);
        end
        drain(20);
        total++;
        if (last_q.size() != 8) begin
            $display("FAIL last_count: got %0d required 8", last_q.size());
            bad++;
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (k >= last_q.size() || last_q[k] !== (LAST_EN && (k % PKT == PKT - 1))) begin
                $display("FAIL last_beat_%0d: got %b required %b",
                         k, (k < last_q.size()) ? last_q[k] : 1'bx, (LAST_EN && (k % PKT == PKT - 1)));
                bad++;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_race();
        test_reset_mid();
        test_random();
        test_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for async_fifo, running entirely in the read clock domain.
- Issues pops on the FIFO read port (rd_en / rd_data / empty) and re-presents the words as a valid/ready stream to downstream logic.
- A 2-entry output buffer plus in-flight tracking hides the FIFO read latency, sustains 1 word/cycle and never pops an empty FIFO.

Parameters:
- Width, 8, data word width; must match the async_fifo Width.
- PktLen, 4, beats per packet for o_last; used only with FIFO_RD_STREAM_LAST_EN; legal range 1..65535.

Ports:
- clk_rd  input  1  read-domain clock, same clock as async_fifo clk_rd.
- rst_n  input  1  asynchronous active-low reset.
- o_rd_en  output  1  pop strobe to async_fifo i_rd_en.
- i_rd_data  input  Width  async_fifo o_rd_data; valid in the cycle after o_rd_en is high.
- i_empty  input  1  async_fifo o_empty, already synchronous to clk_rd.
- o_valid  output  1  stream data valid.
- i_ready  input  1  downstream accept.
- o_data  output  Width  stream data; equals the buffer head.
- o_last  output  1  end-of-packet marker; constant 0 without the macro.
- o_busy  output  1  high while buffer is non-empty or a read is in flight.

Behaviour:
- Clock and reset: one clock, clk_rd. Reset is asynchronous and active-low (rst_n).
- Reset values: o_rd_en=0, o_valid=0, o_data=0, o_last=0, o_busy=0. Buffer count=0, inflight=0, beat counter=0. Buffer contents are don't-care.
- State:
  - 2-entry circular buffer: wr_ptr, rd_ptr (1 bit each), count (0..2).
  - inflight flag = o_rd_en registered.
- pop = o_valid & i_ready (a stream handshake).
- Issue rule (combinational):
  - o_rd_en = !i_empty & ((count + inflight - pop) < 2).
  - i_ready may feed o_rd_en combinationally. Downstream must not derive i_ready from o_rd_en.
- Capture: in any cycle with inflight=1, i_rd_data is written to buf[wr_ptr] at the clock edge; wr_ptr toggles.
- Simultaneous capture and pop: count is unchanged, both pointers advance, and the written slot differs from the head.
- Latency:
  - o_rd_en high in cycle N → data captured at end of N+1 → o_valid high in N+2.
  - With i_ready held high and the FIFO non-empty, throughput is 1 word/cycle after the 2-cycle fill.
- Stream rule: once o_valid=1, o_data holds stable until the pop. o_valid = (count != 0).
- Ordering: words leave in exactly FIFO order, with no drops and no duplicates.
- Overflow invariant: count + inflight ≤ 2 at every edge. Capture never occurs while count == 2 without a simultaneous pop. The bench asserts this.
- Boundaries:
  - Empty rises while a read is in flight: the in-flight word is still captured, and no new pop is issued.
  - i_ready low with buffer full: o_rd_en=0 regardless of i_empty.
  - rst_n asserted mid-transfer: all state clears immediately. The in-flight word is lost (the FIFO is reset with the same rst_n).
- o_busy = (count != 0) | inflight.

Optional Feature:
- Macro FIFO_RD_STREAM_LAST_EN defined:
  - A 16-bit beat counter increments on each pop.
  - o_last = o_valid & (beat == PktLen-1).
  - A pop with o_last=1 clears the counter to 0.
  - Counter reset value is 0.
- Macro not defined: no counter is built and o_last is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with i_empty=0 → o_rd_en=0, o_valid=0, o_busy=0. Release → o_rd_en=1 on the first cycle.
- Streaming: FIFO preloaded with 0x01..0x08, i_ready=1 → o_valid from cycle 2 after the first o_rd_en. Eight consecutive beats 0x01..0x08 with no gaps, then o_valid=0 and o_busy=0.
- Backpressure: 5 words queued, i_ready=0 for 10 cycles → exactly 2 pops issued, o_data=0x01 held stable. Release i_ready → 0x01..0x05 delivered in order.
- Empty race: i_empty rises the cycle after o_rd_en → the in-flight word is still delivered; no o_rd_en while i_empty=1 (assertion).
- Reset mid-burst: rst_n pulsed low for 1 cycle while count=2 → o_valid drops asynchronously to 0; resumes cleanly after the FIFO refills.
- With FIFO_RD_STREAM_LAST_EN and PktLen=4: stream 8 words → o_last=1 on beats 4 and 8 only. The counter holds across i_ready stalls.
